// File: rtl/signed_divider_pkg.sv
// signed_divider_pkg
//   Shared definitions for the signed restoring divider.
//   - DEFAULT_L : default operand/result width
//   - state_t   : controller state encoding (IDLE, ITER, SIGN)
package signed_divider_pkg;

   localparam int DEFAULT_L = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      SIGN = 2'd2
   } state_t;

endpackage

// File: rtl/divider_step.sv
// divider_step
//   One restoring shift/subtract step on unsigned magnitudes.
//   The dividend occupies quo_in.  Its MSB shifts into the partial
//   remainder, and the new quotient bit shifts in at the LSB.
//   Ports:
//     rem_in  [l:0]   partial remainder before the step
//     quo_in  [l-1:0] dividend/quotient shift register before the step
//     divisor [l-1:0] divisor magnitude
//     rem_out [l:0]   partial remainder after the step
//     quo_out [l-1:0] shift register after the step
module divider_step #(
   parameter int l = 16
) (
   input  logic [l:0]   rem_in,
   input  logic [l-1:0] quo_in,
   input  logic [l-1:0] divisor,
   output logic [l:0]   rem_out,
   output logic [l-1:0] quo_out
);

   logic [l+1:0] trial;
   logic [l+1:0] diff;

   always_comb begin
      trial = {rem_in, quo_in[l-1]};
      diff  = trial - {2'b00, divisor};
      // A clear top bit on the difference means trial >= divisor: keep it.
      if (!diff[l+1]) begin
         rem_out = diff[l:0];
         quo_out = {quo_in[l-2:0], 1'b1};
      end else begin
         rem_out = trial[l:0];
         quo_out = {quo_in[l-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/signed_divider.sv
// signed_divider
//   Multi-cycle two's-complement divider with a fixed latency.  The
//   quotient is truncated toward zero, and the remainder takes the sign
//   of the dividend.
//   Ports:
//     CLK, RST      clock, synchronous active-high reset
//     Start         request; accepted only while Ready
//     A, B [l-1:0]  dividend, divisor (signed)
//     Ready         idle and able to accept Start
//     Q, Rem        registered quotient / remainder
//     Done          one-cycle pulse marking results valid
//     DivZero       divisor was zero (valid with Done)
module signed_divider
   import signed_divider_pkg::*;
#(
   parameter int l = DEFAULT_L
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         Start,
   input  logic [l-1:0] A,
   input  logic [l-1:0] B,
   output logic         Ready,
   output logic [l-1:0] Q,
   output logic [l-1:0] Rem,
   output logic         Done,
   output logic         DivZero
);

   localparam int CW = $clog2(l + 1);

   state_t state_reg, state_next;

   logic [CW-1:0] count_reg;
   logic [l:0]    prem_reg;      // partial remainder
   logic [l-1:0]  quo_reg;       // dividend shifting out, quotient shifting in
   logic [l-1:0]  divisor_reg;
   logic          sign_a_reg;
   logic          sign_b_reg;
   logic          zero_b_reg;

   logic [l-1:0]  q_reg;
   logic [l-1:0]  rem_reg;
   logic          done_reg;
   logic          divzero_reg;

   logic [l:0]    step_rem;
   logic [l-1:0]  step_quo;
   logic [l-1:0]  a_mag;
   logic [l-1:0]  b_mag;

   // The magnitude of the most negative value is its own bit pattern.
   // Read as unsigned, this is 2^(l-1), so no saturation is needed.
   assign a_mag = A[l-1] ? -A : A;
   assign b_mag = B[l-1] ? -B : B;

   divider_step #(.l(l)) u_step (
      .rem_in  (prem_reg),
      .quo_in  (quo_reg),
      .divisor (divisor_reg),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_ff @(posedge CLK) begin
      if (RST) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (Start) state_next = ITER;
         ITER: if (count_reg == CW'(1)) state_next = SIGN;
         SIGN: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_reg   <= '0;
         prem_reg    <= '0;
         quo_reg     <= '0;
         divisor_reg <= '0;
         sign_a_reg  <= 1'b0;
         sign_b_reg  <= 1'b0;
         zero_b_reg  <= 1'b0;
         q_reg       <= '0;
         rem_reg     <= '0;
         done_reg    <= 1'b0;
         divzero_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (Start) begin
                  count_reg   <= CW'(l);
                  prem_reg    <= '0;
                  quo_reg     <= a_mag;
                  divisor_reg <= b_mag;
                  sign_a_reg  <= A[l-1];
                  sign_b_reg  <= B[l-1];
                  zero_b_reg  <= (B == '0);
               end
            end
            ITER: begin
               count_reg <= count_reg - CW'(1);
               prem_reg  <= step_rem;
               quo_reg   <= step_quo;
            end
            SIGN: begin
               // A zero divisor reports all ones in Q.  Rem is |A| given
               // the dividend's sign back, which is A itself.
               if (zero_b_reg)
                  q_reg <= '1;
               else if (sign_a_reg ^ sign_b_reg)
                  q_reg <= -quo_reg;
               else
                  q_reg <= quo_reg;
               rem_reg     <= sign_a_reg ? -prem_reg[l-1:0] : prem_reg[l-1:0];
               divzero_reg <= zero_b_reg;
               done_reg    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Ready   = (state_reg == IDLE);
   assign Q       = q_reg;
   assign Rem     = rem_reg;
   assign Done    = done_reg;
   assign DivZero = divzero_reg;

endmodule

// File: tb/tb_signed_divider.sv
module tb_signed_divider;

   localparam int L = 16;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         Start = 1'b0;
   logic [L-1:0] A = '0;
   logic [L-1:0] B = '0;
   logic         Ready;
   logic [L-1:0] Q;
   logic [L-1:0] Rem;
   logic         Done;
   logic         DivZero;

   int checks = 0;
   int errors = 0;

   signed_divider #(.l(L)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .Start   (Start),
      .A       (A),
      .B       (B),
      .Ready   (Ready),
      .Q       (Q),
      .Rem     (Rem),
      .Done    (Done),
      .DivZero (DivZero)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge. Presents a request, which the next posedge accepts,
   // and ends at the negedge after the accepting edge.
   task automatic start_op(input logic [L-1:0] a, input logic [L-1:0] b);
      A = a;
      B = b;
      Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
      @(negedge CLK);
   endtask

   // Steps negedges until Done is seen. n counts posedges since acceptance.
   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!Done && n < 60) begin
         @(negedge CLK);
         n++;
      end
   endtask

   // Called at the negedge where Done should be high.
   task automatic check_result(input string tag, input int lat, input logic [L-1:0] eq,
                               input logic [L-1:0] er, input logic edz);
      $display("op %s: Q=%h Rem=%h DivZero=%0b latency=%0d", tag, Q, Rem, DivZero, lat);
      check({tag, " latency"}, lat, 17);
      check({tag, " Done"}, Done, 1'b1);
      check({tag, " Q"}, Q, eq);
      check({tag, " Rem"}, Rem, er);
      check({tag, " DivZero"}, DivZero, edz);
      check({tag, " Ready"}, Ready, 1'b1);
      @(negedge CLK);
      check({tag, " Done pulse"}, Done, 1'b0);
      check({tag, " Q hold"}, Q, eq);
      check({tag, " Rem hold"}, Rem, er);
   endtask

   task automatic do_div(input string tag, input logic [L-1:0] a, input logic [L-1:0] b,
                         input logic [L-1:0] eq, input logic [L-1:0] er, input logic edz);
      int n;
      start_op(a, b);
      check({tag, " busy"}, Ready, 1'b0);
      wait_done(0, n);
      check_result(tag, n, eq, er, edz);
   endtask

   initial begin
      int n;
      int done_seen;

      // reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      check("reset Ready", Ready, 1'b1);
      check("reset Q", Q, 16'h0000);
      check("reset Rem", Rem, 16'h0000);
      check("reset Done", Done, 1'b0);
      check("reset DivZero", DivZero, 1'b0);

      do_div("100/7",    16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0);
      do_div("-100/7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0);
      do_div("100/-7",   16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0);
      do_div("-100/-7",  16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0);
      do_div("min/-1",   16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
      do_div("min/1",    16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0);
      do_div("7/100",    16'd7,    16'd100,  16'h0000, 16'h0007, 1'b0);
      do_div("5/0",      16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1);
      do_div("-5/0",     16'hFFFB, 16'd0,    16'hFFFF, 16'hFFFB, 1'b1);
      do_div("1000/-9",  16'd1000, 16'hFFF7, 16'hFF91, 16'h0001, 1'b0);

      // A mid-ITER Start carrying other operands is ignored, and so are
      // operand changes made right after acceptance.
      A = 16'd100; B = 16'd7; Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0; A = 16'd50; B = 16'd3;
      @(negedge CLK);
      repeat (5) @(negedge CLK);
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      wait_done(6, n);
      check_result("ignore start", n, 16'h000E, 16'h0002, 1'b0);

      // Reset during the 5th ITER cycle aborts the division.
      start_op(16'd1000, 16'hFFF7);
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort Ready", Ready, 1'b1);
      check("abort Q", Q, 16'h0000);
      check("abort Rem", Rem, 16'h0000);
      check("abort Done", Done, 1'b0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (Done) done_seen++;
      end
      check("abort no Done", done_seen, 0);
      do_div("after abort", 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0);

      // Start held high through Done gives back-to-back operations.
      A = 16'd100; B = 16'd7; Start = 1'b1;
      @(posedge CLK);
      #1 A = 16'd1000; B = 16'hFFF7;
      @(negedge CLK);
      wait_done(0, n);
      check_result("b2b first", n, 16'h000E, 16'h0002, 1'b0);
      // check_result stepped past the edge that accepted the second request.
      Start = 1'b0;
      wait_done(0, n);
      check_result("b2b second", n, 16'hFF91, 16'h0001, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
